round_controller: RTL and testbench

//   Parametrised round/timer/lives sequencer for the door-guessing game. Replaces the fixed
//   two-player timer + pause logic in the top level. Runs a per-round seconds countdown,

---
 rtl/round_controller.sv | 157 +++++++++++++++
 tb/tb_round_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Round/timer/lives sequencer for the door-guessing game: per-round seconds countdown,
// judge at time-up, reveal pause, then the next round or game over with a winner.
module round_controller #(
  parameter int NUM_PLAYERS   = 2,
  parameter int DOOR_W        = 2,
  parameter int LIVES_W       = 2,
  parameter int INIT_LIVES    = 3,
  parameter int ROUND_SECS    = 10,
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int PAUSE_TICKS   = 25_000_000,
  localparam int WIN_W        = $clog2(NUM_PLAYERS)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic [NUM_PLAYERS*DOOR_W-1:0]  correct_door_i,
  input  logic [NUM_PLAYERS*DOOR_W-1:0]  player_pos_i,
  output logic [3:0]                     seconds_left_o,
  output logic                           time_up_o,
  output logic                           resume_o,
  output logic [NUM_PLAYERS*LIVES_W-1:0] lives_o,
  output logic [NUM_PLAYERS-1:0]         alive_o,
  output logic [7:0]                     round_num_o,
  output logic                           game_over_o,
  output logic                           winner_valid_o,
  output logic [WIN_W-1:0]               winner_o,
  output logic [1:0]                     state_o
);

  localparam int CNT_MAX = (TICKS_PER_SEC > PAUSE_TICKS) ? TICKS_PER_SEC : PAUSE_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [3:0]       SECS_INIT  = 4'(ROUND_SECS);
  localparam logic [NUM_PLAYERS*LIVES_W-1:0] LIVES_INIT =
    {NUM_PLAYERS{LIVES_W'(INIT_LIVES)}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_REVEAL    = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t                         state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [3:0]                     secs_q;
  logic                           time_up_q;
  logic                           resume_q;
  logic [NUM_PLAYERS*LIVES_W-1:0] lives_q;
  logic [7:0]                     round_q;
  logic                           game_over_q;
  logic                           winner_valid_q;
  logic [WIN_W-1:0]               winner_q;

  logic [NUM_PLAYERS*LIVES_W-1:0] lives_d;
  logic [3:0]                     live_cnt;
  logic [WIN_W-1:0]               sole_idx;

  // Judged lives, live-lane count and the last live lane index, all from lives_q.
  always_comb begin
    lives_d  = lives_q;
    alive_o  = '0;
    live_cnt = '0;
    sole_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive_o[i] = |lives_q[i*LIVES_W +: LIVES_W];
      if (alive_o[i] &&
          (player_pos_i[i*DOOR_W +: DOOR_W] != correct_door_i[i*DOOR_W +: DOOR_W])) begin
        lives_d[i*LIVES_W +: LIVES_W] = lives_q[i*LIVES_W +: LIVES_W] - LIVES_W'(1);
      end
      if (alive_o[i]) begin
        live_cnt = live_cnt + 4'd1;
        sole_idx = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      secs_q         <= '0;
      time_up_q      <= 1'b0;
      resume_q       <= 1'b0;
      lives_q        <= '0;
      round_q        <= '0;
      game_over_q    <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_q       <= '0;
    end else begin
      resume_q <= 1'b0;
      case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (start_i) begin
            state_q        <= S_COUNTDOWN;
            cnt_q          <= '0;
            secs_q         <= SECS_INIT;
            lives_q        <= LIVES_INIT;
            round_q        <= 8'd1;
            game_over_q    <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= '0;
          end
        end
        S_COUNTDOWN: begin
          if (cnt_q == TICK_LAST) begin
            cnt_q <= '0;
            if (secs_q == 4'd1) begin
              // Time-up edge: inputs are sampled and judged only here.
              state_q   <= S_REVEAL;
              secs_q    <= '0;
              time_up_q <= 1'b1;
              lives_q   <= lives_d;
            end else begin
              secs_q <= secs_q - 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_REVEAL: begin
          if (cnt_q == PAUSE_LAST) begin
            cnt_q     <= '0;
            time_up_q <= 1'b0;
            resume_q  <= 1'b1;
            if (live_cnt >= 4'd2) begin
              state_q <= S_COUNTDOWN;
              secs_q  <= SECS_INIT;
              if (round_q != 8'hFF) round_q <= round_q + 8'd1;
            end else begin
              state_q        <= S_GAME_OVER;
              game_over_q    <= 1'b1;
              winner_valid_q <= (live_cnt == 4'd1);
              winner_q       <= (live_cnt == 4'd1) ? sole_idx : '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign seconds_left_o = secs_q;
  assign time_up_o      = time_up_q;
  assign resume_o       = resume_q;
  assign lives_o        = lives_q;
  assign round_num_o    = round_q;
  assign game_over_o    = game_over_q;
  assign winner_valid_o = winner_valid_q;
  assign winner_o       = winner_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenario sequence with randomized door/position
// data, checked against a per-round timeline and lives model.
module tb_round_controller;

  localparam int NP    = 2;
  localparam int SECS  = 3;
  localparam int TPS   = 4;
  localparam int PAUSE = 5;
  localparam int INITL = 3;
  localparam int R     = SECS * TPS;
  localparam int LAST  = R + PAUSE + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] correct_door = '0;
  logic [3:0] player_pos = '0;
  logic [3:0] seconds_left;
  logic       time_up, resume, game_over, winner_valid;
  logic [3:0] lives;
  logic [1:0] alive;
  logic [7:0] round_num;
  logic       winner;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int mdl_lives[NP];
  int mdl_round = 0;

  round_controller #(
    .NUM_PLAYERS(NP), .DOOR_W(2), .LIVES_W(2), .INIT_LIVES(INITL),
    .ROUND_SECS(SECS), .TICKS_PER_SEC(TPS), .PAUSE_TICKS(PAUSE)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .correct_door_i(correct_door), .player_pos_i(player_pos),
    .seconds_left_o(seconds_left), .time_up_o(time_up), .resume_o(resume),
    .lives_o(lives), .alive_o(alive), .round_num_o(round_num),
    .game_over_o(game_over), .winner_valid_o(winner_valid), .winner_o(winner),
    .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mdl_pack();
    return {2'(mdl_lives[1]), 2'(mdl_lives[0])};
  endfunction

  function automatic logic [1:0] mdl_alive();
    return {mdl_lives[1] != 0, mdl_lives[0] != 0};
  endfunction

  function automatic int mdl_count();
    return int'(mdl_lives[0] != 0) + int'(mdl_lives[1] != 0);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".secs"}, seconds_left, 0);
    chk({tag, ".time_up"}, time_up, 0);
    chk({tag, ".resume"}, resume, 0);
    chk({tag, ".lives"}, lives, 0);
    chk({tag, ".alive"}, alive, 0);
    chk({tag, ".round"}, round_num, 0);
    chk({tag, ".game_over"}, game_over, 0);
    chk({tag, ".winner_valid"}, winner_valid, 0);
    chk({tag, ".winner"}, winner, 0);
  endtask

  // Pulses start for one edge; leaves the bench at the negedge of round cycle 1.
  task automatic start_game();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NP; i++) mdl_lives[i] = INITL;
    mdl_round = 1;
  endtask

  // Walks one round from its cycle 1 to the cycle after the reveal ends.
  // right[i]=1 means lane i picks its correct door at the judging edge.
  task automatic run_round(input logic [1:0] right, input bit noise, input int stop_k);
    logic [1:0] d, p;
    int n;
    for (int k = 1; k <= LAST; k++) begin
      if (k <= R) begin
        chk("secs_count", seconds_left, SECS - (k - 1) / TPS);
        chk("time_up_low", time_up, 0);
      end else if (k < LAST) begin
        chk("secs_zero", seconds_left, 0);
        chk("time_up_high", time_up, 1);
      end
      if (k > 1 && k < LAST) chk("resume_low", resume, 0);
      if (k == 1) begin
        chk("lives_start", lives, mdl_pack());
        chk("round_start", round_num, mdl_round);
        chk("game_over_low", game_over, 0);
      end
      if (k == R + 1) begin
        chk("lives_judged", lives, mdl_pack());
        chk("alive_judged", alive, mdl_alive());
      end
      if (k == stop_k) begin
        start = 1'b0;
        return;
      end
      if (k == LAST) begin
        start = 1'b0;
        chk("resume_pulse", resume, 1);
        chk("time_up_end", time_up, 0);
        n = mdl_count();
        if (n >= 2) begin
          if (mdl_round < 255) mdl_round++;
          chk("secs_reload", seconds_left, SECS);
          chk("round_next", round_num, mdl_round);
          chk("game_over_cont", game_over, 0);
        end else begin
          chk("game_over_set", game_over, 1);
          chk("winner_valid", winner_valid, n == 1);
          chk("winner", winner, (n == 1 && mdl_lives[1] != 0) ? 1 : 0);
          chk("round_held", round_num, mdl_round);
          chk("lives_final", lives, mdl_pack());
        end
      end else begin
        if (k == R) begin
          for (int i = 0; i < NP; i++) begin
            d = 2'($urandom);
            p = right[i] ? d : d + 2'($urandom_range(1, 3));
            correct_door[i*2 +: 2] = d;
            player_pos[i*2 +: 2] = p;
            if (!right[i] && mdl_lives[i] > 0) mdl_lives[i]--;
          end
        end else begin
          correct_door = 4'($urandom);
          player_pos = 4'($urandom);
        end
        if (noise) start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [1:0] rmask;
    // Reset and idle
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_secs", seconds_left, 0);
    chk("idle_round", round_num, 0);

    // Lane 1 loses every round from round 2 on; lane 0 wins
    start_game();
    run_round(2'b11, 1'b0, 0);
    run_round(2'b01, 1'b0, 0);
    run_round(2'b01, 1'b1, 0);
    run_round(2'b01, 1'b0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("game_over_hold", game_over, 1);
      chk("lives_hold", lives, mdl_pack());
    end

    // Both lanes eliminated on the same judge
    start_game();
    run_round(2'b00, 1'b1, 0);
    run_round(2'b00, 1'b1, 0);
    run_round(2'b00, 1'b0, 0);

    // Random outcomes until game over
    start_game();
    for (int r = 0; r < 10 && mdl_count() >= 2; r++) begin
      rmask = 2'($urandom);
      run_round(rmask, 1'b1, 0);
    end
    chk("random_game_over", game_over, 1);

    // Round counter saturation, then lane 1 wins
    start_game();
    for (int r = 0; r < 258; r++) run_round(2'b11, 1'b0, 0);
    chk("round_sat", round_num, 255);
    for (int r = 0; r < 3; r++) run_round(2'b10, 1'b0, 0);

    // Reset in the middle of the reveal pause
    start_game();
    run_round(2'b11, 1'b0, R + 3);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reveal_reset");
    reset = 1'b0;
    repeat (PAUSE + 2) begin
      @(negedge clk);
      chk("post_reset_resume", resume, 0);
      chk("post_reset_time_up", time_up, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
